// File: rtl/grid_planning_pkg.sv
// Shared constants and geometry helpers for the multi-obstacle grid planning game.
package grid_planning_pkg;

    // Bit positions inside a 4-bit direction request {right,left,up,down}
    localparam int DIR_DOWN  = 0;
    localparam int DIR_UP    = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;

    // Highest legal coordinate on a 3K x 3K grid
    function automatic int grid_max(input int k);
        return 3 * k - 1;
    endfunction

    // Column just west of the lower wall
    function automatic int wall_lo_west(input int k);
        return k - 1;
    endfunction

    // Column just east of the lower wall
    function automatic int wall_lo_east(input int k);
        return k;
    endfunction

    // Column just west of the upper wall
    function automatic int wall_hi_west(input int k);
        return 2 * k - 1;
    endfunction

    // Column just east of the upper wall
    function automatic int wall_hi_east(input int k);
        return 2 * k;
    endfunction

    // A westward step from (x,y) would cross a wall
    function automatic logic left_blocked(input int x, input int y, input int k);
        return ((x == wall_lo_east(k)) && (y < 2 * k)) ||
               ((x == wall_hi_east(k)) && (y >= 2 * k));
    endfunction

    // An eastward step from (x,y) would cross a wall
    function automatic logic right_blocked(input int x, input int y, input int k);
        return ((x == wall_lo_west(k)) && (y < 2 * k)) ||
               ((x == wall_hi_west(k)) && (y >= 2 * k));
    endfunction

endpackage

// File: rtl/grid_obstacle.sv
// One environment-driven obstacle: position, clamped moves, maintenance counter.
module grid_obstacle
    import grid_planning_pkg::*;
#(
    parameter int K         = 3,
    parameter int CW        = 4,
    parameter int MAINT_EN  = 0,
    parameter int MAINT_BIT = 1,
    parameter int INIT_X    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          notfirst,
    input  logic          rt,
    input  logic [3:0]    dir,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y
);

    localparam logic [CW-1:0] MAX_C  = CW'(grid_max(K));
    localparam logic [CW-1:0] INIT_C = CW'(INIT_X);
    localparam logic [CW-1:0] ONE_C  = CW'(1);
    localparam logic [CW-1:0] ZERO_C = CW'(0);

    logic [CW-1:0] x_r;
    logic [CW-1:0] y_r;
    logic [7:0]    cnt_r;
    logic [CW-1:0] x_nxt_s;
    logic [CW-1:0] y_nxt_s;
    logic [7:0]    cnt_nxt_s;
    logic          maint_s;

    assign maint_s = (MAINT_EN != 0) ? cnt_r[MAINT_BIT] : 1'b0;

    // Next position (up beats down, left beats right, clamped per axis) and counter
    always_comb begin
        x_nxt_s   = x_r;
        y_nxt_s   = y_r;
        cnt_nxt_s = cnt_r;
        if (rt && !maint_s) begin
            if (dir[DIR_UP]) begin
                if (y_r != MAX_C) y_nxt_s = y_r + ONE_C;
                else              y_nxt_s = y_r;
            end else if (dir[DIR_DOWN]) begin
                if (y_r != ZERO_C) y_nxt_s = y_r - ONE_C;
                else               y_nxt_s = y_r;
            end else begin
                y_nxt_s = y_r;
            end
            if (dir[DIR_LEFT]) begin
                if (x_r != ZERO_C) x_nxt_s = x_r - ONE_C;
                else               x_nxt_s = x_r;
            end else if (dir[DIR_RIGHT]) begin
                if (x_r != MAX_C) x_nxt_s = x_r + ONE_C;
                else              x_nxt_s = x_r;
            end else begin
                x_nxt_s = x_r;
            end
        end else begin
            x_nxt_s = x_r;
            y_nxt_s = y_r;
        end
        if (rt) begin
            if (cnt_r < 8'd128) cnt_nxt_s = cnt_r + 8'd1;
            else                cnt_nxt_s = 8'd0;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Position and counter registers; first edge after reset places the obstacle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r   <= ZERO_C;
            y_r   <= ZERO_C;
            cnt_r <= 8'd0;
        end else begin
            if (!notfirst) begin
                x_r <= INIT_C;
                y_r <= ZERO_C;
            end else begin
                x_r <= x_nxt_s;
                y_r <= y_nxt_s;
            end
            cnt_r <= cnt_nxt_s;
        end
    end

    assign x = x_r;
    assign y = y_r;

endmodule

// File: rtl/grid_planning_multi.sv
// Grid planning game: one robot, N_OBS obstacles, token exclusivity, error and goal flags.
module grid_planning_multi
    import grid_planning_pkg::*;
#(
    parameter int K         = 3,
    parameter int N_OBS     = 2,
    parameter int CW        = 4,
    parameter int WALLS     = 1,
    parameter int MAINT_EN  = 0,
    parameter int MAINT_BIT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               move_robot,
    input  logic [3:0]         ctl_dir,
    input  logic [4*N_OBS-1:0] move_obs,
    output logic               error,
    output logic               goal,
    output logic               _rt_robot,
    output logic [N_OBS-1:0]   _rt_obs,
    output logic [CW-1:0]      robot_x,
    output logic [CW-1:0]      robot_y,
    output logic               coll
);

    localparam logic [CW-1:0] MAX_C  = CW'(grid_max(K));
    localparam logic [CW-1:0] ONE_C  = CW'(1);
    localparam logic [CW-1:0] ZERO_C = CW'(0);

    logic             notfirst_r, excl_r, error_r, goal_r;
    logic [CW-1:0]    rx_r, ry_r, rx_nxt_s, ry_nxt_s;
    logic             live_s, rt_robot_s, cur_excl_s, coll_s;
    logic             can_left_s, can_right_s, error_nxt_s, goal_nxt_s;
    logic [N_OBS-1:0] rt_obs_s;
    logic [3:0]       tok_cnt_s;
    logic [CW-1:0]    obs_x_s [N_OBS];
    logic [CW-1:0]    obs_y_s [N_OBS];

    genvar gi;
    generate
        for (gi = 0; gi < N_OBS; gi++) begin : g_obs
            grid_obstacle #(
                .K(K), .CW(CW), .MAINT_EN(MAINT_EN), .MAINT_BIT(MAINT_BIT),
                .INIT_X(2 * (gi + 1))
            ) u_obs (
                .clk(clk), .rst_n(rst_n), .notfirst(notfirst_r), .rt(rt_obs_s[gi]),
                .dir(move_obs[4*gi +: 4]), .x(obs_x_s[gi]), .y(obs_y_s[gi])
            );
        end
    endgenerate

    // Tokens, exclusivity of this step, and collision on registered positions
    always_comb begin
        live_s     = notfirst_r & ~error_r & ~goal_r;
        rt_robot_s = live_s & move_robot;
        rt_obs_s   = {N_OBS{1'b0}};
        tok_cnt_s  = {3'b000, rt_robot_s};
        coll_s     = 1'b0;
        for (int i = 0; i < N_OBS; i++) begin
            rt_obs_s[i] = live_s & (|move_obs[4*i +: 4]);
            tok_cnt_s   = tok_cnt_s + {3'b000, rt_obs_s[i]};
            if ((obs_x_s[i] == rx_r) && (obs_y_s[i] == ry_r)) coll_s = 1'b1;
            else                                               coll_s = coll_s;
        end
        cur_excl_s  = (tok_cnt_s <= 4'd1);
        error_nxt_s = error_r | (excl_r & cur_excl_s & coll_s);
        goal_nxt_s  = goal_r | ((rx_r == MAX_C) && (ry_r == MAX_C) && !error_nxt_s);
    end

    // Robot step: single axis, priority down/up/left/right with fall-through
    always_comb begin
        rx_nxt_s    = rx_r;
        ry_nxt_s    = ry_r;
        can_left_s  = (rx_r != ZERO_C) &&
                      !((WALLS != 0) && left_blocked(int'(rx_r), int'(ry_r), K));
        can_right_s = (rx_r != MAX_C) &&
                      !((WALLS != 0) && right_blocked(int'(rx_r), int'(ry_r), K));
        if (rt_robot_s) begin
            if (ctl_dir[DIR_DOWN] && (ry_r != ZERO_C))   ry_nxt_s = ry_r - ONE_C;
            else if (ctl_dir[DIR_UP] && (ry_r != MAX_C)) ry_nxt_s = ry_r + ONE_C;
            else if (ctl_dir[DIR_LEFT] && can_left_s)    rx_nxt_s = rx_r - ONE_C;
            else if (ctl_dir[DIR_RIGHT] && can_right_s)  rx_nxt_s = rx_r + ONE_C;
            else begin
                rx_nxt_s = rx_r;
                ry_nxt_s = ry_r;
            end
        end else begin
            rx_nxt_s = rx_r;
            ry_nxt_s = ry_r;
        end
    end

    // Game state registers; the first edge after reset only arms the game
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            notfirst_r <= 1'b0;
            excl_r     <= 1'b0;
            error_r    <= 1'b0;
            goal_r     <= 1'b0;
            rx_r       <= ZERO_C;
            ry_r       <= ZERO_C;
        end else begin
            notfirst_r <= 1'b1;
            if (!notfirst_r) excl_r <= 1'b1;
            else             excl_r <= excl_r & cur_excl_s;
            error_r <= error_nxt_s;
            goal_r  <= goal_nxt_s;
            rx_r    <= rx_nxt_s;
            ry_r    <= ry_nxt_s;
        end
    end

    assign error     = error_r;
    assign goal      = goal_r;
    assign _rt_robot = rt_robot_s;
    assign _rt_obs   = rt_obs_s;
    assign robot_x   = rx_r;
    assign robot_y   = ry_r;
    assign coll      = coll_s;

endmodule

// File: tb/tb_grid_planning_multi.sv
// Bench: walled/no-maintenance instance (a) and open/maintenance instance (b), shared stimulus.
module tb_grid_planning_multi;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       move_robot = 1'b0;
    logic [3:0] ctl_dir = 4'd0;
    logic [7:0] move_obs = 8'd0;

    logic       a_error, a_goal, a_rt_robot, a_coll, b_error, b_goal, b_rt_robot, b_coll;
    logic [1:0] a_rt_obs, b_rt_obs;
    logic [3:0] a_x, a_y, b_x, b_y;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [3:0] D_DN = 4'b0001, D_UP = 4'b0010, D_LF = 4'b0100, D_RT = 4'b1000;

    typedef struct {
        logic [7:0] mr, dir, mo, rt_a;
        logic [7:0] ax, ay, ac, ae;
        logic [7:0] bx, by, bc, be;
    } vec_t;

    vec_t tbl [10];
    vec_t sb_q [$];
    vec_t exp_v;

    always #5 clk = ~clk;

    grid_planning_multi #(.K(3), .N_OBS(2), .CW(4), .WALLS(1), .MAINT_EN(0), .MAINT_BIT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .move_robot(move_robot), .ctl_dir(ctl_dir), .move_obs(move_obs),
        .error(a_error), .goal(a_goal), ._rt_robot(a_rt_robot), ._rt_obs(a_rt_obs),
        .robot_x(a_x), .robot_y(a_y), .coll(a_coll)
    );

    grid_planning_multi #(.K(3), .N_OBS(2), .CW(4), .WALLS(0), .MAINT_EN(1), .MAINT_BIT(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .move_robot(move_robot), .ctl_dir(ctl_dir), .move_obs(move_obs),
        .error(b_error), .goal(b_goal), ._rt_robot(b_rt_robot), ._rt_obs(b_rt_obs),
        .robot_x(b_x), .robot_y(b_y), .coll(b_coll)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic [3:0] dir, input logic [7:0] mo);
        move_robot = mr;
        ctl_dir    = dir;
        move_obs   = mo;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asserted away from any edge: outputs must clear with no clock edge
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        drive(1'b1, 4'hf, 8'hff);
        check({tag, " a_x"}, a_x, 0);        check({tag, " a_y"}, a_y, 0);
        check({tag, " a_coll"}, a_coll, 1);  check({tag, " a_err"}, a_error, 0);
        check({tag, " a_goal"}, a_goal, 0);  check({tag, " a_rt_robot"}, a_rt_robot, 0);
        check({tag, " a_rt_obs"}, a_rt_obs, 0);
        check({tag, " b_x"}, b_x, 0);        check({tag, " b_err"}, b_error, 0);
        check({tag, " b_goal"}, b_goal, 0);  check({tag, " b_rt_obs"}, b_rt_obs, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 4'd0, 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // mr dir mo rt_a | ax ay ac ae | bx by bc be
        tbl[0] = '{8'd1, 8'(D_UP), 8'h00, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        tbl[1] = '{8'd1, 8'(D_UP), 8'h00, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0};
        tbl[2] = '{8'd1, 8'(D_RT), 8'h00, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd1, 8'd1, 8'd0, 8'd0};
        tbl[3] = '{8'd1, 8'(D_RT), 8'h00, 8'd1, 8'd2, 8'd1, 8'd0, 8'd0, 8'd2, 8'd1, 8'd0, 8'd0};
        tbl[4] = '{8'd1, 8'(D_RT), 8'h00, 8'd1, 8'd2, 8'd1, 8'd0, 8'd0, 8'd3, 8'd1, 8'd0, 8'd0};
        tbl[5] = '{8'd1, 8'(D_DN), 8'h00, 8'd1, 8'd2, 8'd0, 8'd1, 8'd0, 8'd3, 8'd0, 8'd0, 8'd0};
        tbl[6] = '{8'd0, 8'd0,     8'h00, 8'd0, 8'd2, 8'd0, 8'd1, 8'd1, 8'd3, 8'd0, 8'd0, 8'd0};
        tbl[7] = '{8'd1, 8'(D_RT), 8'h00, 8'd0, 8'd2, 8'd0, 8'd1, 8'd1, 8'd4, 8'd0, 8'd1, 8'd0};
        tbl[8] = '{8'd0, 8'd0,     8'h00, 8'd0, 8'd2, 8'd0, 8'd1, 8'd1, 8'd4, 8'd0, 8'd1, 8'd1};
        tbl[9] = '{8'd1, 8'(D_RT), 8'h00, 8'd0, 8'd2, 8'd0, 8'd1, 8'd1, 8'd4, 8'd0, 8'd1, 8'd1};

        tick();
        do_reset("rst0");

        // Walk, wall stop, collision and error latching
        for (int i = 0; i < 10; i++) begin
            move_robot = tbl[i].mr[0];
            ctl_dir    = tbl[i].dir[3:0];
            move_obs   = tbl[i].mo;
            sb_q.push_back(tbl[i]);
            #1;
            check($sformatf("p1[%0d] a_rt_robot", i), a_rt_robot, tbl[i].rt_a);
            tick();
            exp_v = sb_q.pop_front();
            check($sformatf("p1[%0d] a_x", i), a_x, exp_v.ax);
            check($sformatf("p1[%0d] a_y", i), a_y, exp_v.ay);
            check($sformatf("p1[%0d] a_coll", i), a_coll, exp_v.ac);
            check($sformatf("p1[%0d] a_err", i), a_error, exp_v.ae);
            check($sformatf("p1[%0d] b_x", i), b_x, exp_v.bx);
            check($sformatf("p1[%0d] b_y", i), b_y, exp_v.by);
            check($sformatf("p1[%0d] b_coll", i), b_coll, exp_v.bc);
            check($sformatf("p1[%0d] b_err", i), b_error, exp_v.be);
        end

        // Exclusivity lost: collisions no longer count; obstacle clamp and maintenance stalls
        do_reset("rst1");
        tick();
        drive(1'b1, D_RT, 8'h01);
        check("p2 a_rt_robot", a_rt_robot, 1);
        check("p2 a_rt_obs", a_rt_obs, 2'b01);
        tick();
        check("p2 a_x", a_x, 1);
        drive(1'b1, D_RT, 8'h00); tick();
        check("p2 a_coll_dn_clamp", a_coll, 1);
        check("p2 b_coll_dn_clamp", b_coll, 1);
        drive(1'b0, 4'd0, 8'h00); tick();
        check("p2 a_err_noexcl", a_error, 0);
        check("p2 b_err_noexcl", b_error, 0);
        drive(1'b0, 4'd0, 8'h03); tick();
        check("p2 a_coll_updn", a_coll, 0);
        drive(1'b1, D_UP, 8'h00); tick();
        check("p2 a_coll_up", a_coll, 1);
        check("p2 b_coll_up", b_coll, 1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'd0, 8'h08); tick();
            check($sformatf("p2 maint[%0d] a_coll", i), a_coll, 0);
            check($sformatf("p2 maint[%0d] b_coll", i), b_coll, (i < 2) ? 1 : 0);
        end
        drive(1'b1, D_RT, 8'h00); tick();
        check("p2 a_x_wall", a_x, 2);
        check("p2 b_x_open", b_x, 3);
        check("p2 b_coll_5th", b_coll, 1);
        check("p2 a_coll_5th", a_coll, 0);
        check("p2 a_err_end", a_error, 0);

        // Obstacle border: clamp at right edge, left beats right at x=8
        do_reset("rst2");
        tick();
        drive(1'b1, D_RT, 8'h80); tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 4'd0, 8'h80); tick();
        end
        drive(1'b0, 4'd0, 8'hC0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 4'd0, 8'h40); tick();
        end
        check("p3 a_coll_x2", a_coll, 0);
        drive(1'b0, 4'd0, 8'h40); tick();
        check("p3 a_coll_x1", a_coll, 1);
        check("p3 a_err", a_error, 0);

        // Walk to the far corner; goal freezes tokens; then async reset mid-run
        do_reset("rst3");
        tick();
        drive(1'b1, D_DN | D_UP, 8'h00); tick();
        check("p4 a_y_fallthru", a_y, 1);
        check("p4 b_y_fallthru", b_y, 1);
        for (int i = 0; i < 17; i++) begin
            if (i < 5)       drive(1'b1, D_UP, 8'h00);
            else if (i < 10) drive(1'b1, D_RT, 8'h00);
            else if (i < 11) drive(1'b1, D_DN, 8'h00);
            else if (i < 14) drive(1'b1, D_RT, 8'h00);
            else             drive(1'b1, D_UP, 8'h00);
            tick();
        end
        check("p4 a_x", a_x, 8);  check("p4 a_y", a_y, 8);
        check("p4 b_x", b_x, 8);  check("p4 b_y", b_y, 8);
        check("p4 a_goal_early", a_goal, 0);
        drive(1'b0, 4'd0, 8'h00); tick();
        check("p4 a_goal", a_goal, 1);
        check("p4 b_goal", b_goal, 1);
        drive(1'b1, D_DN, 8'hff);
        check("p4 a_rt_robot", a_rt_robot, 0);
        check("p4 a_rt_obs", a_rt_obs, 0);
        check("p4 b_rt_obs", b_rt_obs, 0);
        tick();
        check("p4 a_y_hold", a_y, 8);
        do_reset("rst4");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/grid_planning_multi.md
Name: grid_planning_multi

Overview:
- Parametrised successor of the single-obstacle grid planning game, used as a synthesis/model-checking benchmark.
- Models one controllable robot and N_OBS environment-driven obstacles on a 3K x 3K grid, with optional thin walls and per-obstacle maintenance stalls.
- Tracks real-time token exclusivity across all movers.
- Raises a sticky error on collision and a sticky goal flag when the robot reaches the far corner.

Parameters:
K, 3, grid side = 3K cells; coordinates 0..3K-1
N_OBS, 2, number of obstacles; 1..4; requires 2*N_OBS <= 3K-1
CW, 4, coordinate width; requires 2^CW >= 3K
WALLS, 1, 1 enables the two thin walls; 0 gives an open grid
MAINT_EN, 0, 1 enables per-obstacle maintenance stalls
MAINT_BIT, 1, bit of the obstacle move counter that flags maintenance; 0..7

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
move_robot  in  1  robot requests a move this step
ctl_dir  in  4  robot direction request {right,left,up,down}; bit0=down
move_obs  in  4*N_OBS  per obstacle i, bits [4i+3:4i] = {right,left,up,down}
error  out  1  sticky collision flag
goal  out  1  sticky goal-reached flag
_rt_robot  out  1  robot real-time token
_rt_obs  out  N_OBS  obstacle real-time tokens
robot_x  out  CW  robot column
robot_y  out  CW  robot row
coll  out  1  combinational: robot shares a cell with any obstacle

Behaviour:
- Reset is asynchronous and active-low. Asserting rst_n=0 at any time, including mid-run, immediately sets:
  - notfirst=0, excl=0, error=0, goal=0
  - robot=(0,0); every obstacle=(0,0); all counters=0
  - resulting outputs: _rt_robot=0, _rt_obs=0, robot_x=robot_y=0, coll=1
- The first rising edge after reset is the init step:
  - notfirst<=1, excl<=1
  - obstacle i is placed at x=2(i+1), y=0
  - no robot move occurs
- Token gating: live = notfirst & !error & !goal.
  - _rt_robot = live & move_robot.
  - _rt_obs[i] = live & |move_obs[i].
- Exclusivity: cur_excl = (popcount of _rt_robot and all _rt_obs) <= 1. When notfirst=1, each edge applies excl <= excl & cur_excl. Once excl falls to 0, it stays 0 until reset.
- Collision:
  - error <= error | (excl & cur_excl & coll).
  - coll is evaluated on the pre-edge registered positions.
  - error therefore rises one edge after the colliding positions are first registered.
- Goal: goal <= goal | (robot at (3K-1,3K-1) & !error). If both error and goal would set on the same edge, error wins and goal stays 0.
- Obstacle i moves only when _rt_obs[i]=1 and maint[i]=0:
  - Vertical: up has priority over down. Horizontal: left has priority over right.
  - Vertical and horizontal updates are independent, so a diagonal step is allowed.
  - Each axis is clamped to 0..3K-1; a clamped move is a no-op on that axis.
  - Obstacles may overlap each other. Walls do not apply to obstacles.
- Maintenance (MAINT_EN=1):
  - Counter cnt[i] (8 bit) advances on every edge where _rt_obs[i]=1, including while stalled.
  - Sequence: if cnt<128 then cnt+1, else 0 (period 129).
  - maint[i] = cnt[i][MAINT_BIT].
  - With MAINT_EN=0, maint is held at 0 and the counter is still kept.
- Robot moves only when _rt_robot=1 and only one axis per step. Priority order: down, up, left, right.
  - down: y>0; up: y<3K-1.
  - left: x>0 and not left-blocked. right: x<3K-1 and not right-blocked.
  - With WALLS=1:
    - left-blocked = (x==K & y<2K) | (x==2K & y>=2K).
    - right-blocked = (x==K-1 & y<2K) | (x==2K-1 & y>=2K).
  - A request that fails its condition falls through to the next requested direction in priority order. If none succeeds, the robot holds.
- Obstacle and robot updates on the same edge are all applied; cur_excl alone decides whether that edge still counts toward error.

Decomposition:
- Package grid_planning_pkg:
  - direction bit indices DIR_DOWN/UP/LEFT/RIGHT
  - constant functions for grid max (3K-1) and wall x positions (K-1, K, 2K-1, 2K)
  - wall predicate functions left_blocked(x,y) and right_blocked(x,y)
- Sub-module grid_obstacle, generated N_OBS times:
  - holds the obstacle's position, maintenance counter, clamp logic and init placement
  - exports x and y
- The top level keeps the robot, excl, error, goal and token logic.

Test Plan:
- K=3, N_OBS=2: release reset, idle one edge -> obs0=(2,0), obs1=(4,0), excl=1, error=0; with move_robot=1 on that first edge the robot stays at (0,0).
- Robot up, right, right, right with WALLS=1 -> path (0,1),(1,1),(2,1),(2,1), where the final right is wall-blocked; same stimulus with WALLS=0 -> ends at (3,1).
- Robot right, right to (2,0) onto obs0 -> coll=1, then error=1 on the next edge; afterwards _rt_robot=0 with move_robot=1, and the robot holds.
- move_robot=1 and move_obs[0]=4'b0001 on the same edge -> excl=0; the robot then walks into obs0 -> coll=1 but error stays 0.
- Border checks: obs0 with down at y=0 -> y holds; up+down together -> y+1; left+right at x=8 -> x=7. MAINT_EN=1, MAINT_BIT=1: obs0 third and fourth moves ignored (cnt=2,3), fifth move applies.
- Robot reaches (8,8) -> goal=1 and tokens are 0. Assert rst_n=0 mid-run -> error, goal and positions clear without waiting for a clock edge.
